// File: rtl/prf_wr_arbiter.sv
// prf_wr_arbiter: shares the banked PRF write ports among the writeback
// requesters, with one round-robin arbiter per bank and registered outputs.
//
// Ports:
//   CLK, RST                  clock, asynchronous active-high reset
//   WB_valid_by_rq            requester r holds a write
//   WB_PR_by_rq               destination PR per requester (bank = PR[1:0])
//   WB_data_by_rq             write data per requester
//   WB_ready_by_rq            combinational grant, handshake = valid & ready
//   bank_stall_by_bank        block all grants to a bank this cycle
//   prf_WEN_by_bank           registered bank write enable
//   prf_waddr_by_bank         registered row within bank (PR[6:2])
//   prf_wdata_by_bank         registered write data
//   complete_valid_by_bank    registered completion broadcast valid
//   complete_PR_by_bank       registered full PR tag of the completed write
module prf_wr_arbiter #(
    parameter int RQ_COUNT   = 7,
    parameter int BANK_COUNT = 4,
    parameter int PR_W       = 7,
    parameter int DATA_W     = 32
) (
    input  logic                                CLK,
    input  logic                                RST,
    input  logic [RQ_COUNT-1:0]                 WB_valid_by_rq,
    input  logic [RQ_COUNT-1:0][PR_W-1:0]       WB_PR_by_rq,
    input  logic [RQ_COUNT-1:0][DATA_W-1:0]     WB_data_by_rq,
    output logic [RQ_COUNT-1:0]                 WB_ready_by_rq,
    input  logic [BANK_COUNT-1:0]               bank_stall_by_bank,
    output logic [BANK_COUNT-1:0]               prf_WEN_by_bank,
    output logic [BANK_COUNT-1:0][PR_W-3:0]     prf_waddr_by_bank,
    output logic [BANK_COUNT-1:0][DATA_W-1:0]   prf_wdata_by_bank,
    output logic [BANK_COUNT-1:0]               complete_valid_by_bank,
    output logic [BANK_COUNT-1:0][PR_W-1:0]     complete_PR_by_bank
);

    localparam int BANK_W = $clog2(BANK_COUNT);
    localparam int PTR_W  = $clog2(RQ_COUNT);
    localparam int ROW_W  = PR_W - 2;

    logic [BANK_COUNT-1:0][PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [BANK_COUNT-1:0]             grant_v;
    logic [BANK_COUNT-1:0][PTR_W-1:0]  grant_idx;
    logic [RQ_COUNT-1:0]               ready_raw;

    logic [BANK_COUNT-1:0]             wen_q, wen_d;
    logic [BANK_COUNT-1:0][ROW_W-1:0]  waddr_q, waddr_d;
    logic [BANK_COUNT-1:0][DATA_W-1:0] wdata_q, wdata_d;
    logic [BANK_COUNT-1:0][PR_W-1:0]   cpr_q, cpr_d;

    // Index of the i-th requester in scan order starting at the pointer.
    function automatic int scan_idx(input int p, input int i);
        int s;
        s = p + i;
        return (s >= RQ_COUNT) ? s - RQ_COUNT : s;
    endfunction

    always_comb begin
        int j;
        j         = 0;
        grant_v   = '0;
        grant_idx = '0;
        ready_raw = '0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            if (!bank_stall_by_bank[b]) begin
                for (int i = 0; i < RQ_COUNT; i++) begin
                    j = scan_idx(int'(rr_ptr_q[b]), i);
                    if (!grant_v[b] && WB_valid_by_rq[j] &&
                        WB_PR_by_rq[j][BANK_W-1:0] == BANK_W'(b)) begin
                        grant_v[b]   = 1'b1;
                        grant_idx[b] = PTR_W'(j);
                    end
                end
            end
            // A requester targets exactly one bank, so it can win at most one.
            if (grant_v[b]) begin
                ready_raw[grant_idx[b]] = 1'b1;
            end
        end
    end

    assign WB_ready_by_rq = RST ? '0 : ready_raw;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wen_d    = '0;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        cpr_d    = cpr_q;
        for (int b = 0; b < BANK_COUNT; b++) begin
            if (grant_v[b]) begin
                rr_ptr_d[b] = (grant_idx[b] == PTR_W'(RQ_COUNT - 1)) ?
                              '0 : grant_idx[b] + 1'b1;
                wen_d[b]    = 1'b1;
                cpr_d[b]    = WB_PR_by_rq[grant_idx[b]];
                waddr_d[b]  = cpr_d[b][PR_W-1:PR_W-ROW_W];
                wdata_d[b]  = WB_data_by_rq[grant_idx[b]];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr_ptr_q <= '0;
            wen_q    <= '0;
            waddr_q  <= '0;
            wdata_q  <= '0;
            cpr_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wen_q    <= wen_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            cpr_q    <= cpr_d;
        end
    end

    // The completion broadcast fires exactly when the bank is written.
    assign prf_WEN_by_bank        = wen_q;
    assign complete_valid_by_bank = wen_q;
    assign prf_waddr_by_bank      = waddr_q;
    assign prf_wdata_by_bank      = wdata_q;
    assign complete_PR_by_bank    = cpr_q;

endmodule
